pwm_sequencer: RTL and testbench

Sequences one pwm_driver channel. It generates the periodic `trigger` strobe and feeds slew-limited duty commands on `pwm_source_*` just before each trigger. It also runs a command watchdog (run, then brake, then coast) and latches external faults until software clears them. It sits between the CPU/command register block and pwm_driver.

---
 rtl/pwm_sequencer_pkg.sv | 18 +
 rtl/pwm_sequencer_period.sv | 43 ++++
 rtl/pwm_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pwm_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_sequencer_pkg.sv
// pwm_sequencer_pkg
// Shared types and phase constants for the PWM sequencer slice.
//   seq_state_t  : sequencer mode, encoded to match the 2-bit state port
//   ISSUE_OFFSET : counter value during which pwm_source_valid is high
//   SLEW_OFFSET  : counter value at which the duty slew step is taken
package pwm_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BRAKE = 2'd2,
      FAULT = 2'd3
   } seq_state_t;

   localparam int ISSUE_OFFSET = 1;
   localparam int SLEW_OFFSET  = 2;

endpackage

// File: rtl/pwm_sequencer_period.sv
// period_timer
// Free-running PWM period down-counter with phase strobes.
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset, loads PWM_PERIOD_CYCLES-1
//   trigger    : high for the one cycle the counter is zero
//   slew_tick  : high for the cycle the counter sits at SLEW_OFFSET
//   issue_load : high on the cycle before the issue cycle, so a registered
//                valid lands exactly on counter == ISSUE_OFFSET
module period_timer
   import pwm_sequencer_pkg::*;
#(
   parameter int PWM_PERIOD_CYCLES = 1500
) (
   input  logic clk,
   input  logic reset,
   output logic trigger,
   output logic slew_tick,
   output logic issue_load
);

   localparam int CNT_W = $clog2(PWM_PERIOD_CYCLES);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PWM_PERIOD_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // The counter only re-phases on reset; mode changes elsewhere never touch it,
   // so triggers keep arriving even while the sequencer is idle or faulted.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= RELOAD;
      end else if (count == '0) begin
         count <= RELOAD;
      end else begin
         count <= count - CNT_W'(1);
      end
   end

   assign trigger    = (count == '0);
   assign slew_tick  = (count == CNT_W'(SLEW_OFFSET));
   assign issue_load = (count == CNT_W'(ISSUE_OFFSET + 1));

endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer
// Drives one pwm_driver channel: periodic trigger, slew-limited duty issue just
// before each trigger, a command watchdog (RUN -> BRAKE -> IDLE) and a latched
// external fault that only software can clear.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   cmd_data/cmd_valid: signed target duty, latched on the strobe
//   ext_fault         : level fault input from the driver
//   fault_clear       : strobe, leaves FAULT when ext_fault is low
//   trigger           : one-cycle strobe per PWM period
//   brake, fault      : mode indications to the driver / CPU
//   pwm_source_data/valid : issued duty, valid one cycle before trigger
//   state             : IDLE=0, RUN=1, BRAKE=2, FAULT=3
module pwm_sequencer
   import pwm_sequencer_pkg::*;
#(
   parameter int PWM_PERIOD_CYCLES = 1500,
   parameter int DATA_WIDTH        = 16,
   parameter int SLEW_STEP         = 64,
   parameter int TIMEOUT_PERIODS   = 100,
   parameter int BRAKE_PERIODS     = 50
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] cmd_data,
   input  logic                         cmd_valid,
   input  logic                         ext_fault,
   input  logic                         fault_clear,
   output logic                         trigger,
   output logic                         brake,
   output logic                         fault,
   output logic signed [DATA_WIDTH-1:0] pwm_source_data,
   output logic                         pwm_source_valid,
   output logic [1:0]                   state
);

   localparam int WD_W = $clog2(TIMEOUT_PERIODS + 1);
   localparam int BK_W = $clog2(BRAKE_PERIODS + 1);

   localparam logic signed [DATA_WIDTH-1:0] DUTY_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] DUTY_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] STEP_POS_N = DATA_WIDTH'(SLEW_STEP);
   localparam logic signed [DATA_WIDTH-1:0] STEP_NEG_N = -STEP_POS_N;
   localparam logic signed [DATA_WIDTH:0]   STEP_POS_W = (DATA_WIDTH+1)'(SLEW_STEP);
   localparam logic signed [DATA_WIDTH:0]   STEP_NEG_W = -STEP_POS_W;

   seq_state_t cur_state, nxt_state;

   logic signed [DATA_WIDTH-1:0] target, current, cmd_clamped, step, slewed;
   logic signed [DATA_WIDTH:0]   diff;
   logic [WD_W-1:0]              wd_count;
   logic [BK_W-1:0]              brake_count;
   logic                         slew_tick, issue_load, wd_expire, brake_done;

   period_timer #(
      .PWM_PERIOD_CYCLES (PWM_PERIOD_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .trigger    (trigger),
      .slew_tick  (slew_tick),
      .issue_load (issue_load)
   );

   // The most negative code has no positive twin, so it is pulled in by one to
   // keep the command range symmetric.
   assign cmd_clamped = (cmd_data == DUTY_MIN) ? -DUTY_MAX : cmd_data;

   // One extra bit keeps target-current from wrapping at full-scale swings.
   assign diff = {target[DATA_WIDTH-1], target} - {current[DATA_WIDTH-1], current};

   // Limit the per-period change; the result always lies between current and
   // target, so the add below cannot overflow.
   always_comb begin
      if (diff > STEP_POS_W) begin
         step = STEP_POS_N;
      end else if (diff < STEP_NEG_W) begin
         step = STEP_NEG_N;
      end else begin
         step = diff[DATA_WIDTH-1:0];
      end
   end

   assign slewed     = current + step;
   assign wd_expire  = trigger && (wd_count == WD_W'(TIMEOUT_PERIODS - 1));
   assign brake_done = trigger && (brake_count == BK_W'(BRAKE_PERIODS - 1));

   // State register for the sequencer mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Mode transitions: a fault beats everything, a command beats the watchdog,
   // and FAULT ignores commands until it is cleared.
   always_comb begin
      nxt_state = cur_state;
      if (ext_fault) begin
         nxt_state = FAULT;
      end else begin
         case (cur_state)
            IDLE:    if (cmd_valid) nxt_state = RUN;
            RUN:     if (!cmd_valid && wd_expire) nxt_state = BRAKE;
            BRAKE: begin
               if (cmd_valid) begin
                  nxt_state = RUN;
               end else if (brake_done) begin
                  nxt_state = IDLE;
               end
            end
            FAULT:   if (fault_clear) nxt_state = IDLE;
            default: nxt_state = IDLE;
         endcase
      end
   end

   // Mode indications follow the registered state directly.
   always_comb begin
      brake = (cur_state == BRAKE);
      fault = (cur_state == FAULT);
      state = cur_state;
   end

   // Duty datapath, watchdog and brake counters. Slew and issue only happen in
   // RUN/BRAKE, so IDLE and FAULT leave the driver coasting. Because these are
   // non-blocking updates, a command landing on the slew cycle is seen from the
   // next period onward.
   always_ff @(posedge clk) begin
      if (reset) begin
         target           <= '0;
         current          <= '0;
         wd_count         <= '0;
         brake_count      <= '0;
         pwm_source_valid <= 1'b0;
         pwm_source_data  <= '0;
      end else begin
         pwm_source_valid <= 1'b0;
         if (ext_fault) begin
            target      <= '0;
            current     <= '0;
            wd_count    <= '0;
            brake_count <= '0;
         end else begin
            case (cur_state)
               IDLE: begin
                  if (cmd_valid) begin
                     target   <= cmd_clamped;
                     current  <= '0;
                     wd_count <= '0;
                  end
               end
               RUN: begin
                  if (slew_tick) begin
                     current          <= slewed;
                     pwm_source_valid <= 1'b1;
                     pwm_source_data  <= slewed;
                  end
                  if (cmd_valid) begin
                     target   <= cmd_clamped;
                     wd_count <= '0;
                  end else if (wd_expire) begin
                     target      <= '0;
                     current     <= '0;
                     wd_count    <= '0;
                     brake_count <= '0;
                  end else if (trigger) begin
                     wd_count <= wd_count + WD_W'(1);
                  end
               end
               BRAKE: begin
                  if (issue_load) begin
                     pwm_source_valid <= 1'b1;
                     pwm_source_data  <= '0;
                  end
                  if (cmd_valid) begin
                     target      <= cmd_clamped;
                     wd_count    <= '0;
                     brake_count <= '0;
                  end else if (brake_done) begin
                     brake_count <= '0;
                  end else if (trigger) begin
                     brake_count <= brake_count + BK_W'(1);
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer
// Scoreboard bench for pwm_sequencer. The driver walks edge by edge, feeding a
// behavioural model that pushes expected issues and trigger snapshots into
// queues; an independent monitor pops them when the DUT presents them.
module tb_pwm_sequencer;

   localparam int P  = 8;
   localparam int DW = 16;
   localparam int S  = 64;
   localparam int T  = 3;
   localparam int B  = 2;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic signed [DW-1:0] cmd_data = '0;
   logic                 cmd_valid = 1'b0;
   logic                 ext_fault = 1'b0;
   logic                 fault_clear = 1'b0;
   logic                 trigger, brake, fault, pwm_source_valid;
   logic signed [DW-1:0] pwm_source_data;
   logic [1:0]           state;

   pwm_sequencer #(
      .PWM_PERIOD_CYCLES (P),
      .DATA_WIDTH        (DW),
      .SLEW_STEP         (S),
      .TIMEOUT_PERIODS   (T),
      .BRAKE_PERIODS     (B)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_data         (cmd_data),
      .cmd_valid        (cmd_valid),
      .ext_fault        (ext_fault),
      .fault_clear      (fault_clear),
      .trigger          (trigger),
      .brake            (brake),
      .fault            (fault),
      .pwm_source_data  (pwm_source_data),
      .pwm_source_valid (pwm_source_valid),
      .state            (state)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int data; int st;} issue_t;
   typedef struct {int cyc; int st; int brk; int flt;} trig_t;

   issue_t issueQ[$];
   trig_t  trigQ[$];
   issue_t monIssue;
   trig_t  monTrig;

   int checks = 0;
   int errors = 0;
   int edgeCount = 0;
   int driveEdge = 0;

   // Reference model state: mode uses the state-port numbering.
   int mMode = 0, mTarget = 0, mCurrent = 0, mSince = 0, mBrakeTrig = 0;

   task automatic checkOutput(input string name, input logic signed [31:0] act,
                              input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int clampCmd(input int d);
      return (d == -(2**(DW-1))) ? -(2**(DW-1) - 1) : d;
   endfunction

   // Period-counter value the DUT holds when edge e (1-based after reset) arrives.
   function automatic int phaseAt(input int e);
      return (P - (e % P)) % P;
   endfunction

   // Advance the model across edge e and queue whatever becomes visible after it.
   task automatic modelEdge(input int e, input bit cv, input int cd, input bit ef,
                            input bit fc);
      int ph, issued, diff, step;
      bit issue;
      ph = phaseAt(e);
      issue = 0;
      issued = 0;
      if (ef) begin
         mMode = 3; mTarget = 0; mCurrent = 0; mSince = 0; mBrakeTrig = 0;
      end else begin
         case (mMode)
            0: if (cv) begin
                  mMode = 1; mTarget = clampCmd(cd); mCurrent = 0; mSince = 0;
               end
            1: begin
               if (ph == 2) begin
                  diff = mTarget - mCurrent;
                  step = (diff > S) ? S : ((diff < -S) ? -S : diff);
                  mCurrent = mCurrent + step;
                  issue = 1;
                  issued = mCurrent;
               end
               if (cv) begin
                  mTarget = clampCmd(cd); mSince = 0;
               end else if (ph == 0) begin
                  mSince++;
                  if (mSince == T) begin
                     mMode = 2; mTarget = 0; mCurrent = 0; mBrakeTrig = 0;
                  end
               end
            end
            2: begin
               if (ph == 2) begin
                  issue = 1;
                  issued = 0;
               end
               if (cv) begin
                  mMode = 1; mTarget = clampCmd(cd); mSince = 0;
               end else if (ph == 0) begin
                  mBrakeTrig++;
                  if (mBrakeTrig == B) mMode = 0;
               end
            end
            default: if (fc) mMode = 0;
         endcase
      end
      if (issue) issueQ.push_back('{cyc: e, data: issued, st: mMode});
      if (phaseAt(e + 1) == 0)
         trigQ.push_back('{cyc: e, st: mMode, brk: int'(mMode == 2), flt: int'(mMode == 3)});
   endtask

   // Drive one edge's worth of inputs, model it, then step past the edge.
   task automatic applyStimulus(input bit cv, input int cd, input bit ef, input bit fc);
      int e;
      e = driveEdge + 1;
      cmd_valid   = cv;
      cmd_data    = cd[DW-1:0];
      ext_fault   = ef;
      fault_clear = fc;
      modelEdge(e, cv, cd, ef, fc);
      @(posedge clk);
      #1;
      driveEdge   = e;
      cmd_valid   = 1'b0;
      fault_clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
   endtask

   task automatic cmdAt(input int ph, input int d);
      while (phaseAt(driveEdge + 1) != ph) applyStimulus(0, 0, 0, 0);
      applyStimulus(1, d, 0, 0);
   endtask

   task automatic checkMode(input string tag);
      checkOutput({tag, "_state"}, state, mMode);
      checkOutput({tag, "_brake"}, brake, int'(mMode == 2));
      checkOutput({tag, "_fault"}, fault, int'(mMode == 3));
   endtask

   always @(posedge clk) begin
      if (!reset) edgeCount <= edgeCount + 1;
   end

   // Monitor: pops expectations whenever the DUT issues or triggers, and flags
   // anything that shows up unexpected or fails to show up on time.
   always @(negedge clk) begin
      if (!reset) begin
         if (pwm_source_valid === 1'b1) begin
            if (issueQ.size() == 0) begin
               checkOutput("spurious_valid", 1, 0);
            end else begin
               monIssue = issueQ.pop_front();
               checkOutput("issue_cycle", edgeCount, monIssue.cyc);
               checkOutput("issue_data", pwm_source_data, monIssue.data);
               checkOutput("issue_state", state, monIssue.st);
            end
         end else if (issueQ.size() > 0 && issueQ[0].cyc <= edgeCount) begin
            checkOutput("missed_valid", 0, 1);
            void'(issueQ.pop_front());
         end
         if (trigger === 1'b1) begin
            if (trigQ.size() == 0) begin
               checkOutput("spurious_trigger", 1, 0);
            end else begin
               monTrig = trigQ.pop_front();
               checkOutput("trig_cycle", edgeCount, monTrig.cyc);
               checkOutput("trig_state", state, monTrig.st);
               checkOutput("trig_brake", brake, monTrig.brk);
               checkOutput("trig_fault", fault, monTrig.flt);
            end
         end else if (trigQ.size() > 0 && trigQ[0].cyc <= edgeCount) begin
            checkOutput("missed_trigger", 0, 1);
            void'(trigQ.pop_front());
         end
      end
   end

   initial begin
      logic [DW-1:0] raw;
      int faultLeft;
      bit found;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_trigger", trigger, 0);
      checkOutput("reset_valid", pwm_source_valid, 0);
      checkOutput("reset_data", pwm_source_data, 0);
      checkOutput("reset_state", state, 0);
      checkOutput("reset_brake", brake, 0);
      checkOutput("reset_fault", fault, 0);
      reset = 1'b0;

      // Free-running triggers with no commands.
      idle(3 * P);
      checkMode("idle");

      // Slew up to 200, then down to -100, refreshing the command each period.
      for (int i = 0; i < 6; i++) cmdAt(5, 200);
      for (int i = 0; i < 6; i++) cmdAt(5, -100);

      // Most negative command clamps and is reached without wrapping.
      for (int i = 0; i < 520; i++) cmdAt(5, -32768);
      checkOutput("clamp_reached", mCurrent, -32767);

      // Watchdog: RUN -> BRAKE -> IDLE.
      idle(7 * P);
      checkMode("after_brake");

      // Command on the slew cycle uses the old target.
      cmdAt(5, 100);
      cmdAt(2, -100);
      cmdAt(5, -100);

      // Fault mid-RUN, clear attempts while fault is held, then recovery.
      cmdAt(5, 300);
      idle(P);
      while (phaseAt(driveEdge + 1) != 3) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
      checkMode("fault_entry");
      applyStimulus(0, 0, 1, 1);
      applyStimulus(1, 40, 1, 1);
      checkMode("fault_held");
      idle(3);
      applyStimulus(0, 0, 0, 1);
      checkMode("fault_cleared");
      cmdAt(5, 50);
      cmdAt(5, 50);
      idle(P);

      // Command on the watchdog expiry cycle keeps RUN.
      cmdAt(5, 500);
      found = 0;
      for (int i = 0; i < 10 * P; i++) begin
         if (phaseAt(driveEdge + 1) == 0 && mMode == 1 && mSince == T - 1) begin
            found = 1;
            break;
         end
         applyStimulus(0, 0, 0, 0);
      end
      checkOutput("expiry_found", found, 1);
      applyStimulus(1, 500, 0, 0);
      checkMode("expiry_cmd");
      idle(P);
      applyStimulus(1, 777, 1, 0);
      checkMode("fault_with_cmd");
      idle(2);
      applyStimulus(0, 0, 0, 1);
      idle(2 * P);
      checkMode("idle_after_fault");

      // Randomized traffic.
      faultLeft = 0;
      for (int i = 0; i < 2000; i++) begin
         bit cv, ef, fc;
         raw = DW'($urandom);
         if ($urandom_range(0, 7) == 0) raw = {1'b1, {(DW-1){1'b0}}};
         cv = ($urandom_range(0, 9) == 0);
         if (faultLeft > 0) begin
            faultLeft--;
         end else if ($urandom_range(0, 199) == 0) begin
            faultLeft = $urandom_range(1, 4);
         end
         ef = (faultLeft > 0);
         fc = ($urandom_range(0, 19) == 0);
         applyStimulus(cv, int'($signed(raw)), ef, fc);
      end
      applyStimulus(0, 0, 0, 1);
      idle(2 * P);
      checkMode("final");

      checkOutput("leftover_issues", issueQ.size(), 0);
      checkOutput("leftover_triggers", trigQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
